// File: rtl/ball_obstacle_judge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ball_obstacle_judge_pkg
// Purpose  : Shared game types and constants for the obstacle/score judge.
// Revision : 1.0 - initial release
// ============================================================================
package ball_obstacle_judge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [2:0] BALL_MAX = 3'd5;
    localparam int unsigned BCD_W = 4;

    // Taps 16,14,13,11 expressed as a feedback mask for the right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage : ball_obstacle_judge_pkg
`default_nettype wire

// File: rtl/ball_obstacle_judge_bcd_counter4.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter4
// Purpose  : 4-digit BCD incrementer with synchronous clear, saturating at 9999.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter4
    import ball_obstacle_judge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    localparam int unsigned DIGITS = 4;

    logic [15:0]     r_value;
    logic [15:0]     w_next;
    logic [DIGITS:0] w_carry;
    logic            w_at_max;

    assign w_at_max   = (r_value == 16'h9999);
    assign w_carry[0] = inc && !w_at_max;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] w_nib;
        assign w_nib          = r_value[i*BCD_W +: BCD_W];
        assign w_carry[i+1]   = w_carry[i] && (w_nib == 4'd9);
        assign w_next[i*BCD_W +: BCD_W] = !w_carry[i]     ? w_nib :
                                          (w_nib == 4'd9) ? 4'd0  : w_nib + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 16'h0000;
        end else if (clr) begin
            r_value <= 16'h0000;
        end else begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

endmodule : bcd_counter4
`default_nettype wire

// File: rtl/ball_obstacle_judge.sv
`default_nettype none
// ============================================================================
// Module   : ball_obstacle_judge
// Purpose  : Scrolling obstacle row, collision detection, BCD score and game FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ball_obstacle_judge
    import ball_obstacle_judge_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 8388608,
    parameter int unsigned COLS       = 16,
    parameter int unsigned BALL_COL   = 2,
    parameter int unsigned OBST_H     = 2,
    parameter int unsigned GAP_MIN    = 3,
    parameter bit          SPAWN_MODE = 1'b1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      ball_state,
    output logic [COLS-1:0] obstacle_map,
    output logic [15:0]     score,
    output logic            playing,
    output logic            game_over,
    output logic            tick
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_OVER = OVER;

    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [COLS-1:0]  r_map;
    logic [3:0]       r_gap;
    logic [15:0]      r_lfsr;
    logic             r_playing;
    logic             r_game_over;

    logic             w_in_run;
    logic             w_enter;
    logic             w_clear;
    logic             w_collide;
    logic             w_step;
    logic             w_spawn;
    logic             w_score_inc;
    logic             w_fb;
    logic [15:0]      w_score;

    assign w_in_run  = (r_state == ST_RUN);
    assign w_enter   = !w_in_run && start;
    assign w_clear   = (ball_state > BALL_MAX) || (32'(ball_state) >= OBST_H);
    assign w_collide = w_in_run && r_map[BALL_COL] && !w_clear;
    // A collision in a tick cycle suppresses the whole scroll step
    assign w_step      = w_in_run && r_tick && !w_collide;
    assign w_spawn     = (32'(r_gap) >= GAP_MIN) && (!SPAWN_MODE || r_lfsr[0]);
    assign w_score_inc = w_step && r_map[BALL_COL];
    assign w_fb        = ^(r_lfsr & LFSR_TAPS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)     w_state_nxt = ST_RUN;
            ST_RUN:  if (w_collide) w_state_nxt = ST_OVER;
            ST_OVER: if (start)     w_state_nxt = ST_RUN;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_playing   <= (w_state_nxt == ST_RUN);
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_enter) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (w_in_run) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            r_tick <= w_in_run && !w_collide && (r_cnt == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_map  <= '0;
            r_gap  <= 4'd0;
            r_lfsr <= LFSR_SEED;
        end else if (w_enter) begin
            r_map <= '0;
            r_gap <= 4'd0;
        end else if (w_step) begin
            r_map  <= {w_spawn, r_map[COLS-1:1]};
            r_gap  <= w_spawn ? 4'd0 : ((r_gap == 4'd15) ? 4'd15 : r_gap + 4'd1);
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_enter),
        .inc   (w_score_inc),
        .value (w_score)
    );

    assign obstacle_map = r_map;
    assign score        = w_score;
    assign playing      = r_playing;
    assign game_over    = r_game_over;
    assign tick         = r_tick;

endmodule : ball_obstacle_judge
`default_nettype wire

// File: tb/tb_ball_obstacle_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_obstacle_judge
// Purpose  : Randomized and directed self-checking bench with a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_obstacle_judge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 0, start_b = 0, start_c = 0;
    logic [2:0] ball_a = 0, ball_b = 0, ball_c = 0;
    logic [7:0]  map_a, map_b, map_c;
    logic [15:0] score_a, score_b, score_c;
    logic play_a, play_b, play_c, over_a, over_b, over_c, tick_a, tick_b, tick_c;

    ball_obstacle_judge #(.TICK_DIV(4), .COLS(8), .BALL_COL(1), .OBST_H(2), .GAP_MIN(3),
                          .SPAWN_MODE(1'b0), .LFSR_SEED(16'hACE1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .ball_state(ball_a), .obstacle_map(map_a),
        .score(score_a), .playing(play_a), .game_over(over_a), .tick(tick_a));

    ball_obstacle_judge #(.TICK_DIV(4), .COLS(8), .BALL_COL(1), .OBST_H(2), .GAP_MIN(3),
                          .SPAWN_MODE(1'b1), .LFSR_SEED(16'hACE1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .ball_state(ball_b), .obstacle_map(map_b),
        .score(score_b), .playing(play_b), .game_over(over_b), .tick(tick_b));

    ball_obstacle_judge #(.TICK_DIV(1), .COLS(8), .BALL_COL(1), .OBST_H(2), .GAP_MIN(1),
                          .SPAWN_MODE(1'b0), .LFSR_SEED(16'hACE1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .ball_state(ball_c), .obstacle_map(map_c),
        .score(score_c), .playing(play_c), .game_over(over_c), .tick(tick_c));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Reference model: st 0=idle 1=run 2=over; cyc counts RUN cycles since entry
    typedef struct {
        int st; int cyc; int map; int gap; int lfsr; int score;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 0; m.cyc = 0; m.map = 0; m.gap = 0; m.lfsr = 'hACE1; m.score = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit strt, int ball, int tdiv, int cols,
                                   int bcol, int oh, int gmin, int mode);
        mdl_t n = m;
        bit   tick_now = (m.st == 1) && (m.cyc > 0) && (m.cyc % tdiv == 0);
        bit   at_ball  = ((m.map >> bcol) & 1) != 0;
        bit   spawn;
        int   fb;
        if (m.st != 1) begin
            if (strt) begin
                n.st = 1; n.cyc = 0; n.map = 0; n.gap = 0; n.score = 0;
            end
        end else if (at_ball && ball < oh) begin
            n.st = 2;
        end else begin
            n.cyc = m.cyc + 1;
            if (tick_now) begin
                spawn  = (m.gap >= gmin) && (mode == 0 || (m.lfsr & 1) != 0);
                fb     = ((m.lfsr >> 0) ^ (m.lfsr >> 2) ^ (m.lfsr >> 3) ^ (m.lfsr >> 5)) & 1;
                n.lfsr = (m.lfsr >> 1) | (fb << 15);
                if (at_ball) n.score = (m.score >= 9999) ? 9999 : m.score + 1;
                n.map  = (m.map >> 1) | (int'(spawn) << (cols - 1));
                n.gap  = spawn ? 0 : ((m.gap >= 15) ? 15 : m.gap + 1);
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic cmp(input string nm, input mdl_t m, input int tdiv, input logic [7:0] mp,
                       input logic [15:0] sc, input logic pl, input logic ov, input logic tk);
        chk({nm, "_map"},   32'(mp), 32'(m.map));
        chk({nm, "_score"}, 32'(sc), 32'(to_bcd(m.score)));
        chk({nm, "_play"},  32'(pl), 32'(m.st == 1));
        chk({nm, "_over"},  32'(ov), 32'(m.st == 2));
        chk({nm, "_tick"},  32'(tk), 32'((m.st == 1) && (m.cyc > 0) && (m.cyc % tdiv == 0)));
    endtask

    mdl_t ma, mb, mc;
    bit   prev_tick_b = 0;
    int   tick_cnt_b  = 0;
    int   last_spawn_b = -1;
    int   spawns_b    = 0;

    always @(posedge clk) begin
        if (rst) begin
            ma = mreset(); mb = mreset(); mc = mreset();
        end else begin
            ma = mstep(ma, start_a, int'(ball_a), 4, 8, 1, 2, 3, 0);
            mb = mstep(mb, start_b, int'(ball_b), 4, 8, 1, 2, 3, 1);
            mc = mstep(mc, start_c, int'(ball_c), 1, 8, 1, 2, 1, 0);
        end
        #1;
        cmp("a", ma, 4, map_a, score_a, play_a, over_a, tick_a);
        cmp("b", mb, 4, map_b, score_b, play_b, over_b, tick_b);
        cmp("c", mc, 1, map_c, score_c, play_c, over_c, tick_c);
        if (prev_tick_b && play_b) begin
            tick_cnt_b++;
            if (map_b[7]) begin
                if (last_spawn_b >= 0) chk("b_spawn_gap", 32'(tick_cnt_b - last_spawn_b >= 4), 1);
                last_spawn_b = tick_cnt_b;
                spawns_b++;
            end
        end
        prev_tick_b = tick_b;
    end

    task automatic pulse_a();
        @(negedge clk) start_a = 1;
        @(negedge clk) start_a = 0;
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int idle_ticks;
        bit done;
        repeat (3) @(negedge clk);
        rst = 0;

        // Reset mid-run, then idle
        ball_a = 3'd5;
        pulse_a();
        repeat (10) @(negedge clk);
        rst = 1;
        #1;
        chk("async_rst_play", 32'(play_a), 0);
        chk("async_rst_map", 32'(map_a), 0);
        @(negedge clk) rst = 0;
        idle_ticks = 0;
        repeat (100) begin
            @(posedge clk); #2;
            if (tick_a) idle_ticks++;
        end
        chk("idle_ticks", 32'(idle_ticks), 0);
        chk("idle_score", 32'(score_a), 0);
        chk("idle_over", 32'(over_a), 0);

        // Deterministic scroll
        pulse_a();
        after_edges(47);
        chk("scroll_score1", 32'(score_a), 32'h0001);
        after_edges(16);
        chk("scroll_score2", 32'(score_a), 32'h0002);
        chk("scroll_over", 32'(over_a), 0);

        @(negedge clk) ball_a = 3'd0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #2;
            if (over_a) done = 1;
        end
        chk("wait_over", 32'(done), 1);

        // Restart from OVER and collide at the ball column
        pulse_a();
        after_edges(1);
        chk("restart_map", 32'(map_a), 0);
        chk("restart_score", 32'(score_a), 0);
        after_edges(2);
        chk("restart_tick_early", 32'(tick_a), 0);
        after_edges(1);
        chk("restart_tick_first", 32'(tick_a), 1);
        after_edges(38);
        chk("coll_over", 32'(over_a), 1);
        chk("coll_play", 32'(play_a), 0);
        chk("coll_map", 32'(map_a), 32'h22);
        chk("coll_score", 32'(score_a), 0);

        // Drop the ball exactly in the tick-11 cycle
        @(negedge clk) ball_a = 3'd5;
        pulse_a();
        after_edges(44);
        chk("coin_tick11", 32'(tick_a), 1);
        @(negedge clk) ball_a = 3'd1;
        after_edges(1);
        chk("coin_over", 32'(over_a), 1);
        chk("coin_score", 32'(score_a), 0);
        chk("coin_map", 32'(map_a), 32'h22);

        // Random play with occasional restarts and resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ball_a  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            start_a = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk) begin start_a = 0; rst = 0; end

        // LFSR-gated spawning with a start pulse mid-run
        ball_b = 3'd5;
        @(negedge clk) start_b = 1;
        @(negedge clk) start_b = 0;
        repeat (4000) @(negedge clk);
        start_b = 1;
        @(negedge clk) start_b = 0;
        repeat (4010) @(negedge clk);
        chk("lfsr_still_play", 32'(play_b), 1);
        chk("lfsr_spawned", 32'(spawns_b > 100), 1);

        // Score saturation with a one-cycle tick
        ball_c = 3'd5;
        @(negedge clk) start_c = 1;
        @(negedge clk) start_c = 0;
        after_edges(20200);
        chk("sat_score", 32'(score_c), 32'h9999);
        after_edges(100);
        chk("sat_hold", 32'(score_c), 32'h9999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ball_obstacle_judge
`default_nettype wire
